multi_integration_file: RTL and testbench
=========================================

MULTI_INTEGRATION_FILE -- requirements
Module: multi_integration_file

Interface
REQ-001 SHALL have parameter N, default 32: accumulator and data width in bits (8..64).
REQ-002 SHALL have parameter NUM_CH, default 4: channel count (1..N, and at most 64).
REQ-003 SHALL have port csi_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rsi_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port avs_s0_address, input, 8 bits: register address.
REQ-006 SHALL have port avs_s0_write, input, 1 bit: write strobe.
REQ-007 SHALL have port avs_s0_writedata, input, N bits: write data.
REQ-008 SHALL have port avs_s0_read, input, 1 bit: read strobe.
REQ-009 SHALL have port avs_s0_readdata, output, N bits: read data.
REQ-010 SHALL have port avs_s0_readdatavalid, output, 1 bit: marks avs_s0_readdata as valid.
REQ-011 SHALL have port coe_R, output, NUM_CH*N bits: all accumulators concatenated, channel 0 in the LSBs.

Function
REQ-012 SHALL use this address map:
- 0..NUM_CH-1: ACC[ch].
- 0x80: CTRL. Bit0 SAT (1 = saturate, 0 = wrap). Bit1 SUB (1 = a write to ACC subtracts, 0 = it adds).
- 0x81: CLEAR, write-only.
- 0x82: OVF, sticky overflow/underflow flags.
REQ-013 SHALL, on a write to ACC[ch], set ACC[ch] to ACC[ch] ± writedata; the new value is visible on coe_R in the next cycle (latency 1).
REQ-014 SHALL perform arithmetic unsigned, N+1 bits wide; the carry/borrow bit marks overflow (add) or underflow (subtract).
REQ-015 SHALL, on overflow: with SAT=1 load 2^N-1; with SAT=0 load the low N bits. In both modes it sets OVF[ch].
REQ-016 SHALL, on underflow: with SAT=1 load 0; with SAT=0 load the low N bits. In both modes it sets OVF[ch].
REQ-017 SHALL, on a write to CLEAR, zero every ACC[ch] whose writedata bit ch is 1; the other channels are unchanged.
REQ-018 SHALL treat OVF as write-1-to-clear; bits at position NUM_CH and above read 0.
REQ-019 SHALL give a set event priority over a W1C clear of the same OVF bit in the same cycle.
REQ-020 SHALL ignore writes to unmapped addresses, and to ACC addresses at NUM_CH and above.
REQ-021 SHALL return read data with fixed latency 1: avs_s0_readdatavalid is high for exactly one cycle, the cycle after avs_s0_read.
REQ-022 SHALL return 0 for reads of unmapped addresses, with avs_s0_readdatavalid still asserted.
REQ-023 SHALL, when read and write are asserted together, perform the write and return the pre-write value.
REQ-024 SHALL accept back-to-back reads and writes every cycle, with no wait states.
REQ-025 SHALL apply CTRL changes from the first ACC write in the cycle after the CTRL write.

Reset
REQ-026 SHALL, while rsi_reset_n=0, asynchronously force to 0: every ACC, CTRL, OVF, avs_s0_readdata and avs_s0_readdatavalid.
REQ-027 SHALL let a reset mid-operation abort any pending read response: no avs_s0_readdatavalid is issued after reset.
REQ-028 SHALL release reset synchronously to csi_clk; the first access is accepted on the first rising edge with rsi_reset_n=1.

Structure
REQ-029 SHALL place in package integration_pkg: the address constants ADDR_CTRL, ADDR_CLEAR and ADDR_OVF; the CTRL bit indices; and a ctrl_t packed struct.
REQ-030 SHALL instantiate sub-module integration_channel NUM_CH times. Each instance:
- holds one N-bit accumulator;
- has inputs en, sub, sat, clr and data;
- has outputs value and ovf_pulse.
REQ-031 SHALL keep address decode, the CTRL/OVF registers and the read mux in the top level.

Verification
REQ-032 SHALL cover (N=32, NUM_CH=4): after reset, write 55 then 5 to ACC[1] -> coe_R[63:32]=60; the other channels are 0; a read of address 1 returns 60 one cycle later.
REQ-033 SHALL cover: with SAT=1, ACC[0]=0xFFFFFFF0, write 0x20 -> ACC[0]=0xFFFFFFFF and OVF=0x1. With SAT=0, the same stimulus -> ACC[0]=0x10 and OVF=0x1.
REQ-034 SHALL cover: with SUB=1 and SAT=1, ACC[2]=3, write 10 -> ACC[2]=0 and OVF bit2=1. Writing 0x4 to OVF then clears OVF to 0.
REQ-035 SHALL cover: ACC={7,6,5,4}, write 0b0101 to CLEAR -> ACC[0]=0 and ACC[2]=0, ACC[1]=5 and ACC[3]=7 unchanged.
REQ-036 SHALL cover: read and write of ACC[3]=9 in the same cycle with data 1 -> readdata=9, and ACC[3]=10 on the next cycle.
REQ-037 SHALL cover: reset asserted in the cycle after a read -> no avs_s0_readdatavalid, and all outputs are 0 asynchronously.

Source files
------------

// File: rtl/integration_pkg.sv
// Shared constants and types for the multi-channel accumulator.
// Imported by the channel and top-level files.
package integration_pkg;

  localparam logic [7:0] ADDR_CTRL  = 8'h80;
  localparam logic [7:0] ADDR_CLEAR = 8'h81;
  localparam logic [7:0] ADDR_OVF   = 8'h82;

  localparam int CTRL_SAT = 0;
  localparam int CTRL_SUB = 1;

  // Member order places sat at bit 0 and sub at bit 1.
  typedef struct packed {
    logic sub;
    logic sat;
  } ctrl_t;

endpackage

// File: rtl/integration_channel.sv
// One N-bit accumulator with add/subtract, wrap/saturate.
// The carry/borrow out is reported as a single-cycle overflow pulse.
module integration_channel
  import integration_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sub,
  input  logic         sat,
  input  logic         clr,
  input  logic [N-1:0] data,
  output logic [N-1:0] value,
  output logic         ovf_pulse
);

  logic [N-1:0] acc_q;
  logic [N-1:0] acc_d;
  logic [N:0]   res;

  always_comb begin
    res       = sub ? ({1'b0, acc_q} - {1'b0, data})
                    : ({1'b0, acc_q} + {1'b0, data});
    acc_d     = acc_q;
    ovf_pulse = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      ovf_pulse = res[N];
      if (res[N] && sat)
        acc_d = sub ? '0 : '1;
      else
        acc_d = res[N-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign value = acc_q;

endmodule

// File: rtl/multi_integration_file.sv
// Memory-mapped bank of NUM_CH accumulators with CTRL, CLEAR
// and sticky W1C overflow flags; reads return one cycle later.
module multi_integration_file
  import integration_pkg::*;
#(
  parameter int N      = 32,
  parameter int NUM_CH = 4
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  input  logic [7:0]        avs_s0_address,
  input  logic              avs_s0_write,
  input  logic [N-1:0]      avs_s0_writedata,
  input  logic              avs_s0_read,
  output logic [N-1:0]      avs_s0_readdata,
  output logic              avs_s0_readdatavalid,
  output logic [NUM_CH*N-1:0] coe_R
);

  ctrl_t              ctrl_q;
  logic [NUM_CH-1:0]  ovf_q;
  logic [NUM_CH-1:0]  ovf_d;
  logic [NUM_CH-1:0]  ovf_pulse;
  logic [NUM_CH-1:0]  w1c;
  logic [N-1:0]       acc_v [NUM_CH];
  logic [N-1:0]       acc_sel;
  logic [N-1:0]       rdata_d;
  logic               is_acc;
  logic               is_ctrl;
  logic               is_clr;
  logic               is_ovf;

  assign is_acc  = avs_s0_address < 8'(NUM_CH);
  assign is_ctrl = avs_s0_address == ADDR_CTRL;
  assign is_clr  = avs_s0_address == ADDR_CLEAR;
  assign is_ovf  = avs_s0_address == ADDR_OVF;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    integration_channel #(.N(N)) u_ch (
      .clk       (csi_clk),
      .rst_n     (rsi_reset_n),
      .en        (avs_s0_write && avs_s0_address == 8'(i)),
      .sub       (ctrl_q.sub),
      .sat       (ctrl_q.sat),
      .clr       (avs_s0_write && is_clr && avs_s0_writedata[i]),
      .data      (avs_s0_writedata),
      .value     (acc_v[i]),
      .ovf_pulse (ovf_pulse[i])
    );
    assign coe_R[i*N +: N] = acc_v[i];
  end

  // New overflow events win over a simultaneous W1C of the same bit.
  always_comb begin
    w1c   = (avs_s0_write && is_ovf) ? avs_s0_writedata[NUM_CH-1:0] : '0;
    ovf_d = (ovf_q & ~w1c) | ovf_pulse;
  end

  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (avs_s0_address == 8'(i)) acc_sel = acc_v[i];
  end

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      is_acc:  rdata_d = acc_sel;
      is_ctrl: rdata_d[1:0] = ctrl_q;
      is_ovf:  rdata_d[NUM_CH-1:0] = ovf_q;
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      ctrl_q               <= '0;
      ovf_q                <= '0;
      avs_s0_readdata      <= '0;
      avs_s0_readdatavalid <= 1'b0;
    end else begin
      if (avs_s0_write && is_ctrl)
        ctrl_q <= ctrl_t'(avs_s0_writedata[1:0]);
      ovf_q                <= ovf_d;
      avs_s0_readdatavalid <= avs_s0_read;
      if (avs_s0_read)
        avs_s0_readdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_multi_integration_file.sv
// Directed table-driven bench for multi_integration_file
// (N=32, NUM_CH=4) plus hand sequences for the corner cases.
module tb_multi_integration_file;

  localparam int N  = 32;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    addr;
  logic          wr;
  logic [N-1:0]  wdata;
  logic          rd;
  logic [N-1:0]  rdata;
  logic          rdv;
  logic [NC*N-1:0] coe;

  int errors = 0;
  int checks = 0;

  multi_integration_file #(.N(N), .NUM_CH(NC)) dut (
    .csi_clk              (clk),
    .rsi_reset_n          (rst_n),
    .avs_s0_address       (addr),
    .avs_s0_write         (wr),
    .avs_s0_writedata     (wdata),
    .avs_s0_read          (rd),
    .avs_s0_readdata      (rdata),
    .avs_s0_readdatavalid (rdv),
    .coe_R                (coe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         w;
    logic         r;
    logic [7:0]   a;
    logic [N-1:0] d;
    int           ch;
    logic [N-1:0] exp_acc;
    logic [N-1:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic w, input logic r, input logic [7:0] a,
                     input logic [N-1:0] d, input int ch,
                     input logic [N-1:0] ea, input logic [N-1:0] er);
    vec_t v;
    v.w = w; v.r = r; v.a = a; v.d = d;
    v.ch = ch; v.exp_acc = ea; v.exp_rd = er;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] acc(input int ch);
    return coe[ch*N +: N];
  endfunction

  initial begin
    rst_n = 1'b0; addr = '0; wr = 1'b0; wdata = '0; rd = 1'b0;
    #12;
    chk("reset coe_lo", coe[N-1:0], '0);
    chk("reset coe_hi", coe[NC*N-1:NC*N-N], '0);
    chk("reset rdata", rdata, '0);
    chk("reset rdv", {31'd0, rdv}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    add(1, 0, 8'h01, 55,           1, 55,           0);
    add(1, 0, 8'h01, 5,            1, 60,           0);
    add(0, 1, 8'h01, 0,           -1, 0,            60);
    add(0, 1, 8'h00, 0,            0, 0,            0);
    add(0, 1, 8'h02, 0,            3, 0,            0);
    add(0, 1, 8'h90, 0,           -1, 0,            0);
    add(1, 0, 8'h80, 1,           -1, 0,            0);
    add(0, 1, 8'h80, 0,           -1, 0,            1);
    add(1, 0, 8'h00, 32'hFFFFFFF0, 0, 32'hFFFFFFF0, 0);
    add(1, 0, 8'h00, 32'h20,       0, 32'hFFFFFFFF, 0);
    add(0, 1, 8'h82, 0,           -1, 0,            1);
    add(1, 0, 8'h82, 1,           -1, 0,            0);
    add(0, 1, 8'h82, 0,           -1, 0,            0);
    add(1, 0, 8'h80, 0,           -1, 0,            0);
    add(1, 0, 8'h81, 1,            0, 0,            0);
    add(1, 0, 8'h00, 32'hFFFFFFF0, 0, 32'hFFFFFFF0, 0);
    add(1, 0, 8'h00, 32'h20,       0, 32'h10,       0);
    add(0, 1, 8'h82, 0,           -1, 0,            1);
    add(1, 0, 8'h82, 1,           -1, 0,            0);
    add(1, 0, 8'h02, 3,            2, 3,            0);
    add(1, 0, 8'h80, 3,           -1, 0,            0);
    add(1, 0, 8'h02, 10,           2, 0,            0);
    add(0, 1, 8'h82, 0,           -1, 0,            4);
    add(1, 0, 8'h82, 4,           -1, 0,            0);
    add(0, 1, 8'h82, 0,           -1, 0,            0);
    add(1, 0, 8'h80, 2,           -1, 0,            0);
    add(1, 0, 8'h02, 1,            2, 32'hFFFFFFFF, 0);
    add(0, 1, 8'h82, 0,           -1, 0,            4);
    add(1, 0, 8'h82, 32'hF4,      -1, 0,            0);
    add(1, 0, 8'h80, 0,           -1, 0,            0);
    add(1, 0, 8'h04, 77,           3, 0,            0);
    add(0, 1, 8'h04, 0,           -1, 0,            0);
    add(1, 0, 8'h83, 5,            0, 32'h10,       0);
    add(0, 1, 8'h81, 0,           -1, 0,            0);
    add(1, 0, 8'h81, 32'hF,        1, 0,            0);
    add(1, 0, 8'h00, 4,            0, 4,            0);
    add(1, 0, 8'h01, 5,            1, 5,            0);
    add(1, 0, 8'h02, 6,            2, 6,            0);
    add(1, 0, 8'h03, 7,            3, 7,            0);
    add(1, 0, 8'h81, 32'h5,        0, 0,            0);
    add(0, 1, 8'h01, 0,           -1, 0,            5);
    add(0, 1, 8'h02, 0,           -1, 0,            0);
    add(0, 1, 8'h03, 0,           -1, 0,            7);
    add(1, 0, 8'h03, 2,            3, 9,            0);
    add(0, 1, 8'h82, 0,           -1, 0,            0);

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      wr = tbl[i].w; rd = tbl[i].r; addr = tbl[i].a; wdata = tbl[i].d;
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0;
      chk($sformatf("v%0d rdv", i), {31'd0, rdv}, {31'd0, tbl[i].r});
      if (tbl[i].r)
        chk($sformatf("v%0d rdata", i), rdata, tbl[i].exp_rd);
      if (tbl[i].ch >= 0)
        chk($sformatf("v%0d acc%0d", i, tbl[i].ch),
            acc(tbl[i].ch), tbl[i].exp_acc);
    end

    // simultaneous read and write of ACC[3]
    wr = 1'b1; rd = 1'b1; addr = 8'h03; wdata = 1;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    chk("rw rdata", rdata, 9);
    chk("rw acc3", acc(3), 10);
    @(posedge clk); #1;
    chk("rdv one cycle", {31'd0, rdv}, '0);

    // reset in the cycle after a read kills the response
    rd = 1'b1; addr = 8'h03;
    @(posedge clk); #1;
    rd = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst rdv", {31'd0, rdv}, '0);
    chk("rst rdata", rdata, '0);
    chk("rst acc1", acc(1), '0);
    chk("rst acc3", acc(3), '0);
    @(posedge clk); #1;
    chk("rst hold rdv", {31'd0, rdv}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    rd = 1'b1; addr = 8'h80;
    @(posedge clk); #1;
    rd = 1'b0;
    chk("post rst ctrl", rdata, '0);
    chk("post rst rdv", {31'd0, rdv}, 1);
    rd = 1'b1; addr = 8'h82;
    @(posedge clk); #1;
    rd = 1'b0;
    chk("post rst ovf", rdata, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
